rv32_imem_loader: RTL and testbench



---
 rtl/rv32_imem_loader.sv | 208 ++++++++++++++++++++
 tb/tb_rv32_imem_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_imem_loader.sv
// Boot loader: assembles a framed little-endian byte stream into 32-bit instruction
// memory writes and holds the core in reset until the image is complete. Optional
// frame checksum is compiled in with `define RV32_LOADER_CHECKSUM_EN (ADDR_WIDTH <= 15).
module rv32_imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid_in,
    input  logic [7:0]            byte_in,
    output logic                  mem_write_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [31:0]           mem_data_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  error_out,
    output logic                  core_reset_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_e;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_e                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    logic [1:0]              lane_q, lane_d;
    logic [23:0]             word_q, word_d;
    logic                    mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_data_q, mem_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    core_reset_q, core_reset_d;

    logic [15:0]             n_s;
    logic                    len_bad_s;
    logic [ADDR_WIDTH:0]     idx_inc_s;
    logic                    last_word_s;
    logic                    write_fire_s;

`ifdef RV32_LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`endif

    assign n_s         = {byte_in, len_q[7:0]};
    assign len_bad_s   = (n_s == 16'd0) || ({1'b0, n_s} > MAX_WORDS);
    assign idx_inc_s   = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign last_word_s = ({{(15 - ADDR_WIDTH){1'b0}}, idx_inc_s} == len_q);

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            idx_q        <= '0;
            lane_q       <= 2'd0;
            word_q       <= 24'd0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b1;
`ifdef RV32_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_reset_q <= core_reset_d;
`ifdef RV32_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // Next-state and frame datapath
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        lane_d       = lane_q;
        word_d       = word_q;
        write_fire_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (byte_valid_in) begin
                    len_d   = {8'd0, byte_in};
                    state_d = S_LEN_HI;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN_HI: begin
                if (byte_valid_in) begin
                    len_d  = n_s;
                    idx_d  = '0;
                    lane_d = 2'd0;
                    if (len_bad_s) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_DATA: begin
                if (byte_valid_in) begin
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        write_fire_s = 1'b1;
                        idx_d        = idx_inc_s;
                        if (last_word_s) begin
`ifdef RV32_LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        // Bytes enter at the top so b0 ends up lowest after three shifts
                        word_d = {byte_in, word_q[23:8]};
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef RV32_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (byte_valid_in) begin
                    if (csum_add(csum_q, byte_in) == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else begin
                    state_d = S_CSUM;
                end
            end
`endif
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

`ifdef RV32_LOADER_CHECKSUM_EN
    // Running modulo-256 sum over every byte belonging to the frame
    always_comb begin
        if (byte_valid_in && (state_q inside {S_IDLE, S_LEN_HI, S_DATA, S_CSUM})) begin
            csum_d = csum_add(csum_q, byte_in);
        end else begin
            csum_d = csum_q;
        end
    end
`endif

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        mem_write_d  = write_fire_s;
        busy_d       = (state_d == S_LEN_HI) || (state_d == S_DATA) || (state_d == S_CSUM);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
        core_reset_d = (state_d != S_DONE);
        if (write_fire_s) begin
            mem_addr_d = idx_q[ADDR_WIDTH-1:0];
            mem_data_d = {byte_in, word_q};
        end else begin
            mem_addr_d = mem_addr_q;
            mem_data_d = mem_data_q;
        end
    end

    assign mem_write_out  = mem_write_q;
    assign mem_addr_out   = mem_addr_q;
    assign mem_data_out   = mem_data_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign error_out      = error_q;
    assign core_reset_out = core_reset_q;

endmodule

// File: tb/tb_rv32_imem_loader.sv
// Self-checking bench for rv32_imem_loader: table of frame shapes with random payloads
// checked against a frame-level model, plus hand-written timing sequences.
module tb_rv32_imem_loader;

    localparam int AW = 8;
`ifdef RV32_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          byte_valid_in;
    logic [7:0]    byte_in;
    logic          mem_write_out;
    logic [AW-1:0] mem_addr_out;
    logic [31:0]   mem_data_out;
    logic          busy_out;
    logic          done_out;
    logic          error_out;
    logic          core_reset_out;

    rv32_imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .byte_valid_in  (byte_valid_in),
        .byte_in        (byte_in),
        .mem_write_out  (mem_write_out),
        .mem_addr_out   (mem_addr_out),
        .mem_data_out   (mem_data_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .error_out      (error_out),
        .core_reset_out (core_reset_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] len;
        int          gap;
        bit          bad_csum;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
    } vec_t;

    vec_t vecs[9];

    logic [AW+31:0] got_q[$];
    logic           prev_wr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: capture every strobe and require it to be a single-cycle pulse
    always @(negedge clk) begin
        if (mem_write_out === 1'b1) begin
            got_q.push_back({mem_addr_out, mem_data_out});
            chk("write_pulse_one_cycle", {63'd0, prev_wr}, 64'd0);
        end
        prev_wr <= mem_write_out;
    end

    task automatic send_byte(input logic [7:0] b);
        byte_valid_in = 1'b1;
        byte_in       = b;
        @(negedge clk);
        byte_valid_in = 1'b0;
        byte_in       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        byte_valid_in = 1'b0;
        byte_in       = 8'h00;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_mem_write"},  {63'd0, mem_write_out},  64'd0);
        chk({tag, "_busy"},       {63'd0, busy_out},       64'd0);
        chk({tag, "_done"},       {63'd0, done_out},       64'd0);
        chk({tag, "_error"},      {63'd0, error_out},      64'd0);
        chk({tag, "_core_reset"}, {63'd0, core_reset_out}, 64'd1);
    endtask

    // Builds a frame from a table row, computes the expected writes from the frame rules,
    // drives it and compares outcome, writes and post-frame silence.
    task automatic run_frame(input vec_t v, input int row);
        logic [7:0]  bytes[$];
        logic [31:0] words[$];
        logic [7:0]  sum;
        logic [31:0] w;
        logic [7:0]  c;
        bit          legal;
        int          n;
        legal = (v.len != 16'd0) && (int'(v.len) <= (1 << AW));
        n     = legal ? int'(v.len) : 0;
        bytes.push_back(v.len[7:0]);
        bytes.push_back(v.len[15:8]);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            words.push_back(w);
            for (int k = 0; k < 4; k++) bytes.push_back(w[8*k +: 8]);
        end
        if (CSUM_ON && legal) begin
            sum = 8'd0;
            foreach (bytes[i]) sum = sum + bytes[i];
            c = 8'd0 - sum;
            if (v.bad_csum) c = c ^ 8'h01;
            bytes.push_back(c);
        end
        got_q.delete();
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (v.gap > 0) idle($urandom_range(0, v.gap));
        end
        idle(2);
        chk($sformatf("row%0d_write_count", row), 64'(got_q.size()), 64'(v.exp_writes));
        for (int i = 0; i < got_q.size() && i < words.size(); i++) begin
            chk($sformatf("row%0d_addr%0d", row, i), 64'(got_q[i][AW+31:32]), 64'(i));
            chk($sformatf("row%0d_data%0d", row, i), 64'(got_q[i][31:0]), 64'(words[i]));
        end
        chk($sformatf("row%0d_done", row),       {63'd0, done_out},       {63'd0, v.exp_done});
        chk($sformatf("row%0d_error", row),      {63'd0, error_out},      {63'd0, v.exp_err});
        chk($sformatf("row%0d_busy", row),       {63'd0, busy_out},       64'd0);
        chk($sformatf("row%0d_core_reset", row), {63'd0, core_reset_out}, {63'd0, !v.exp_done});
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        idle(2);
        chk($sformatf("row%0d_no_write_after_end", row), 64'(got_q.size()), 64'(v.exp_writes));
    endtask

    initial begin
        vecs[0] = '{16'd1,      0, 1'b0, 1'b1,     1'b0,    1};
        vecs[1] = '{16'd2,      3, 1'b0, 1'b1,     1'b0,    2};
        vecs[2] = '{16'd0,      0, 1'b0, 1'b0,     1'b1,    0};
        vecs[3] = '{16'd257,    0, 1'b0, 1'b0,     1'b1,    0};
        vecs[4] = '{16'd256,    0, 1'b0, 1'b1,     1'b0,    256};
        vecs[5] = '{16'd5,      2, 1'b1, !CSUM_ON, CSUM_ON, 5};
        vecs[6] = '{16'hFFFF,   1, 1'b0, 1'b0,     1'b1,    0};
        vecs[7] = '{16'd7,      4, 1'b0, 1'b1,     1'b0,    7};
        vecs[8] = '{16'd255,    0, 1'b0, 1'b1,     1'b0,    255};

        reset         = 1'b1;
        byte_valid_in = 1'b0;
        byte_in       = 8'h00;
        idle(3);
        reset = 1'b0;
        idle(1);
        check_idle("reset");
        chk("reset_addr", 64'(mem_addr_out), 64'd0);
        chk("reset_data", 64'(mem_data_out), 64'd0);

        // Single word 0x00000013: busy latency, write timing, done timing
        got_q.delete();
        send_byte(8'h01);
        chk("busy_after_len_lo", {63'd0, busy_out}, 64'd1);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("single_write_strobe", {63'd0, mem_write_out}, 64'd1);
        chk("single_write_addr",   64'(mem_addr_out),      64'd0);
        chk("single_write_data",   64'(mem_data_out),      64'h13);
        if (CSUM_ON) begin
            chk("single_done_before_csum", {63'd0, done_out}, 64'd0);
            send_byte(8'hEC);
        end
        chk("single_done",       {63'd0, done_out},       64'd1);
        chk("single_core_reset", {63'd0, core_reset_out}, 64'd0);
        chk("single_busy",       {63'd0, busy_out},       64'd0);
        chk("single_error",      {63'd0, error_out},      64'd0);
        idle(3);
        chk("single_data_holds", 64'(mem_data_out),  64'h13);
        chk("single_one_write",  64'(got_q.size()),  64'd1);

        // Zero length: error in the cycle after LEN_HI
        do_reset();
        got_q.delete();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("len0_error_timing", {63'd0, error_out}, 64'd1);
        chk("len0_busy",         {63'd0, busy_out},  64'd0);

        // Reset after two bytes of word 0 discards the partial word
        do_reset();
        got_q.delete();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        idle(1);
        chk("midword_reset_no_write", 64'(got_q.size()), 64'd0);
        check_idle("midword_reset");
        run_frame(vecs[1], 100);

        foreach (vecs[r]) begin
            do_reset();
            run_frame(vecs[r], r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
